// File: rtl/write_back_regfile_pkg.sv
// Shared Y86 constants: instruction codes, status codes and the "no register" ID.
package write_back_regfile_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    // Register ID meaning "no register"
    localparam int RNONE = 15;

endpackage

// File: rtl/write_back_regfile_dst_decode.sv
// Destination decode for the write-back stage: maps an instruction onto its
// E-port (ALU result) and M-port (memory result) destination register IDs.
module wb_dst_decode
    import write_back_regfile_pkg::*;
#(
    parameter int RID_W  = 4,
    parameter int RSP_ID = 4
) (
    input  logic             valid_i,
    input  logic             halted_i,
    input  logic [3:0]       icode_i,
    input  logic [RID_W-1:0] ra_i,
    input  logic [RID_W-1:0] rb_i,
    input  logic             cnd_i,
    output logic [RID_W-1:0] dst_e_o,
    output logic [RID_W-1:0] dst_m_o
);

    localparam logic [RID_W-1:0] RNONE_ID = RID_W'(RNONE);
    localparam logic [RID_W-1:0] RSP      = RID_W'(RSP_ID);

    // Decode destinations; nothing is written for bubbles or once stopped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dst_e_o = RNONE_ID;
        dst_m_o = RNONE_ID;
        if (valid_i && !halted_i) begin
            case (icode_i)
                IRRMOVQ:                     dst_e_o = cnd_i ? rb_i : RNONE_ID;
                IIRMOVQ, IOPQ:               dst_e_o = rb_i;
                ICALL, IRET, IPUSHQ:         dst_e_o = RSP;
                IPOPQ: begin
                    dst_e_o = RSP;
                    dst_m_o = ra_i;
                end
                IMRMOVQ:                     dst_m_o = ra_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/write_back_regfile.sv
// Y86 write-back stage: architectural register file with two write ports
// (E and M), two read ports with optional forwarding, halt/status latching
// and a retired-instruction counter.
module write_back_regfile
    import write_back_regfile_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter int               NREG     = 15,
    parameter int               RID_W    = 4,
    parameter int               RSP_ID   = 4,
    parameter logic [XLEN-1:0]  RSP_INIT = '0,
    parameter int               BYPASS   = 1,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [3:0]       icode,
    input  logic [RID_W-1:0] rA,
    input  logic [RID_W-1:0] rB,
    input  logic             cnd,
    input  logic [XLEN-1:0]  valE,
    input  logic [XLEN-1:0]  valM,
    input  logic [2:0]       stat_i,
    input  logic [RID_W-1:0] srcA,
    input  logic [RID_W-1:0] srcB,
    output logic [XLEN-1:0]  valA,
    output logic [XLEN-1:0]  valB,
    output logic [RID_W-1:0] dstE,
    output logic [RID_W-1:0] dstM,
    output logic             halted,
    output logic [2:0]       stat_o,
    output logic [CNT_W-1:0] retired
);

    localparam logic [RID_W-1:0] NREG_ID = RID_W'(NREG);

    logic [XLEN-1:0]  regs_q [NREG];
    logic             halted_q, halted_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic live, commit, halt_ev, wr_e, wr_m;

    wb_dst_decode #(
        .RID_W  (RID_W),
        .RSP_ID (RSP_ID)
    ) u_dst_decode (
        .valid_i  (valid_i),
        .halted_i (halted_q),
        .icode_i  (icode),
        .ra_i     (rA),
        .rb_i     (rB),
        .cnd_i    (cnd),
        .dst_e_o  (dstE),
        .dst_m_o  (dstM)
    );

    assign live    = valid_i & ~halted_q;
    assign commit  = live & (stat_i == AOK) & (icode != IHALT);
    assign halt_ev = live & ((icode == IHALT) | (stat_i != AOK));
    // M port wins a shared destination, so E is suppressed there (popq %rsp).
    assign wr_m    = commit & (dstM < NREG_ID);
    assign wr_e    = commit & (dstE < NREG_ID) & (dstE != dstM);

    // Read one port: out-of-range IDs read as zero; forwarding follows write priority.
    function automatic logic [XLEN-1:0] read_port(input logic [RID_W-1:0] src);
        if (src >= NREG_ID)                         return '0;
        else if ((BYPASS != 0) && wr_m && src == dstM) return valM;
        else if ((BYPASS != 0) && wr_e && src == dstE) return valE;
        else                                        return regs_q[src];
    endfunction

    // Combinational read ports.
    always_comb begin
        valA = read_port(srcA);
        valB = read_port(srcB);
    end

    // Next-state for halt/status latch and retired counter.
    always_comb begin
        halted_d  = halted_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        if (halt_ev) begin
            halted_d = 1'b1;
            stat_d   = ((icode == IHALT) && (stat_i == AOK)) ? HLT : stat_i;
        end
        if (commit) retired_d = retired_q + CNT_W'(1);
    end

    // State update; synchronous reset overrides any commit or halt on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            // NOTE: the register file itself is reset, as software relies on a zeroed file and a known stack pointer.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
            end
            halted_q  <= 1'b0;
            stat_q    <= AOK;
            retired_q <= '0;
        end else begin
            halted_q  <= halted_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            if (wr_e) regs_q[dstE] <= valE;
            if (wr_m) regs_q[dstM] <= valM;
        end
    end

    assign halted  = halted_q;
    assign stat_o  = stat_q;
    assign retired = retired_q;

endmodule
